// File: rtl/cache_ctrl_if.sv
// Request/response bus shared by the CPU port and the main-memory port of cache_ctrl.
// The master drives address, data and the rd/we request; the slave answers with spo and a ready pulse.
interface cache_ctrl_if;
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        we;
    logic [31:0] spo;
    logic        ready;

    modport master (output a, output d, output rd, output we, input spo, input ready);
    modport slave  (input a, input d, input rd, input we, output spo, output ready);
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving one cacheway.
// Refills a whole line over the memory bus and validates the tag only on the final beat.
module cache_ctrl #(
    parameter int unsigned LINES           = 128,
    parameter int unsigned WORDS_PER_BLOCK = 32,
    parameter int unsigned TAG_LENGTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_ctrl_if.slave           cpu,
    cache_ctrl_if.master          mem,
    output logic                  way_en,
    output logic [31:0]           way_a,
    output logic [31:0]           way_d,
    output logic                  way_we,
    output logic                  way_tag_we,
    output logic [TAG_LENGTH-1:0] way_tag_in,
    input  logic [TAG_LENGTH-1:0] way_tag_out,
    input  logic [31:0]           way_spo,
    input  logic                  way_init_done
);

    localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned IDX_HI = OFF_W + IDX_W + 2;

    typedef enum logic [2:0] {StInit, StIdle, StLookup, StRefill, StResp, StWthru} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              hit_q, hit_d;
    logic              gap_q, gap_d;
    logic [OFF_W-1:0]  k_q, k_d;

    logic [TAG_LENGTH-1:0] tag_entry;
    logic                  hit;
    logic                  last_beat;
    logic [31:0]           refill_a;

    // An all-zero entry is invalid, so a full-entry compare covers both valid bit and tag field.
    assign tag_entry = TAG_LENGTH'({1'b1, addr_q[31:IDX_HI]});
    assign hit       = (way_tag_out == tag_entry);
    assign refill_a  = {addr_q[31:OFF_W+2], k_q, 2'b00};
    assign last_beat = (k_q == OFF_W'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            gap_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            gap_q   <= gap_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        hit_d   = hit_q;
        gap_d   = gap_q;
        k_d     = k_q;
        unique case (state_q)
            StInit: begin
                if (way_init_done) state_d = StIdle;
            end
            StIdle: begin
                if (cpu.we || cpu.rd) begin
                    addr_d  = cpu.a;
                    data_d  = cpu.d;
                    we_d    = cpu.we;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (we_q) begin
                    hit_d   = hit;
                    state_d = StWthru;
                end else if (hit) begin
                    state_d = StIdle;
                end else begin
                    k_d     = '0;
                    gap_d   = 1'b0;
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (mem.ready) begin
                    if (k_q == addr_q[OFF_W+1:2]) rdata_d = mem.spo;
                    if (last_beat) begin
                        state_d = StResp;
                    end else begin
                        k_d   = k_q + OFF_W'(1);
                        gap_d = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            StWthru: begin
                if (mem.ready) state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_comb begin
        cpu.spo    = '0;
        cpu.ready  = 1'b0;
        mem.a      = '0;
        mem.d      = '0;
        mem.rd     = 1'b0;
        mem.we     = 1'b0;
        way_en     = 1'b0;
        way_a      = addr_q;
        way_d      = '0;
        way_we     = 1'b0;
        way_tag_we = 1'b0;
        way_tag_in = tag_entry;
        unique case (state_q)
            StInit: ;
            StIdle: begin
                // Launch the synchronous way read so data is ready in the lookup cycle.
                way_en = 1'b1;
                way_a  = cpu.a;
            end
            StLookup: begin
                way_en = 1'b1;
                if (!we_q && hit) begin
                    cpu.ready = 1'b1;
                    cpu.spo   = way_spo;
                end
            end
            StRefill: begin
                way_en = 1'b1;
                way_a  = refill_a;
                mem.a  = refill_a;
                mem.rd = !gap_q;
                if (!gap_q && mem.ready) begin
                    way_we     = 1'b1;
                    way_d      = mem.spo;
                    way_tag_we = last_beat;
                end
            end
            StResp: begin
                cpu.ready = 1'b1;
                cpu.spo   = rdata_q;
            end
            StWthru: begin
                way_en = 1'b1;
                mem.we = 1'b1;
                mem.a  = addr_q;
                mem.d  = data_q;
                if (mem.ready) begin
                    cpu.ready = 1'b1;
                    way_we    = hit_q;
                    way_d     = data_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cacheway and memory, scoreboard queues for bus and CPU traffic,
// a vector table for the main transactions and hand sequences for init hold-off and mid-refill reset.
module tb_cache_ctrl;
    localparam int unsigned LINES    = 128;
    localparam int unsigned WPB      = 32;
    localparam int unsigned TAGL     = 32;
    localparam int unsigned LAT      = 1;
    localparam int unsigned INIT_DLY = 128;
    localparam int unsigned OFF_W    = 5;
    localparam int unsigned IDX_HI   = 14;

    typedef struct {bit we; logic [31:0] a; logic [31:0] d;} bus_t;
    typedef struct {bit rd; logic [31:0] d;} rsp_t;
    typedef struct {bit we; logic [31:0] a; logic [31:0] d; bit miss; logic [31:0] exp;} vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if cpu_bus ();
    cache_ctrl_if mem_bus ();

    logic            way_en, way_we, way_tag_we, way_init_done;
    logic [31:0]     way_a, way_d, way_spo;
    logic [TAGL-1:0] way_tag_in, way_tag_out;

    cache_ctrl #(.LINES(LINES), .WORDS_PER_BLOCK(WPB), .TAG_LENGTH(TAGL)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (cpu_bus),
        .mem          (mem_bus),
        .way_en       (way_en),
        .way_a        (way_a),
        .way_d        (way_d),
        .way_we       (way_we),
        .way_tag_we   (way_tag_we),
        .way_tag_in   (way_tag_in),
        .way_tag_out  (way_tag_out),
        .way_spo      (way_spo),
        .way_init_done(way_init_done)
    );

    int n_chk = 0, n_err = 0;
    int n_beats = 0, n_wbeats = 0, n_wayw = 0, n_tagw = 0, n_memrd_cyc = 0, n_rdy = 0;
    logic [31:0] last_tag_a = '0;
    bus_t exp_bus_q[$];
    rsp_t exp_rsp_q[$];
    logic [31:0] mem_w [int unsigned];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string msg);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s", nm, msg);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return mem_w.exists(a) ? mem_w[a] : pat(a);
    endfunction

    // Cacheway model: synchronous data read, combinational tag read, delayed tag-clear completion.
    logic [31:0]     way_mem  [LINES*WPB];
    logic [TAGL-1:0] way_tags [LINES];
    logic [6:0]      w_idx;
    logic [4:0]      w_off;
    int              init_cnt;
    assign w_idx       = way_a[IDX_HI-1:OFF_W+2];
    assign w_off       = way_a[OFF_W+1:2];
    assign way_tag_out = way_tags[w_idx];

    always @(posedge clk) begin
        if (rst) begin
            init_cnt      <= 0;
            way_init_done <= 1'b0;
            for (int i = 0; i < LINES; i++) way_tags[i] <= '0;
        end else begin
            if (!way_init_done) begin
                init_cnt <= init_cnt + 1;
                if (init_cnt == INIT_DLY - 1) way_init_done <= 1'b1;
            end
            if (way_en) begin
                way_spo <= way_mem[{w_idx, w_off}];
                if (way_we) way_mem[{w_idx, w_off}] <= way_d;
                if (way_tag_we) way_tags[w_idx] <= way_tag_in;
            end
        end
    end

    // Memory responder: ready pulse LAT+1 cycles after a request, checked against the bus queue.
    initial begin
        int   lat_cnt;
        bus_t e;
        lat_cnt = 0;
        mem_bus.ready = 1'b0;
        mem_bus.spo   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || mem_bus.ready) begin
                mem_bus.ready = 1'b0;
                lat_cnt = 0;
            end else if (mem_bus.rd || mem_bus.we) begin
                if (lat_cnt < int'(LAT)) begin
                    lat_cnt++;
                end else begin
                    lat_cnt = 0;
                    if (exp_bus_q.size() == 0) begin
                        fail("bus_unexpected", $sformatf("got access at %h want none", mem_bus.a));
                    end else begin
                        e = exp_bus_q.pop_front();
                        check("bus_we", 32'(mem_bus.we), 32'(e.we));
                        check("bus_addr", mem_bus.a, e.a);
                        if (e.we) check("bus_wdata", mem_bus.d, e.d);
                    end
                    if (mem_bus.we) begin
                        mem_w[mem_bus.a] = mem_bus.d;
                        n_wbeats++;
                    end else begin
                        mem_bus.spo = mem_val(mem_bus.a);
                        n_beats++;
                    end
                    mem_bus.ready = 1'b1;
                end
            end
        end
    end

    // Output monitor: counts way/bus activity and pops the CPU response scoreboard.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mem_bus.rd) n_memrd_cyc++;
            if (way_en && way_we) n_wayw++;
            if (way_en && way_tag_we) begin
                n_tagw++;
                last_tag_a = way_a;
            end
            if (cpu_bus.ready) begin
                n_rdy++;
                if (exp_rsp_q.size() == 0) begin
                    fail("cpu_ready_unexpected", $sformatf("got ready, data %h, want none", cpu_bus.spo));
                end else begin
                    r = exp_rsp_q.pop_front();
                    if (r.rd) check("cpu_spo", cpu_bus.spo, r.d);
                end
            end
        end
    end

    task automatic run(input vec_t v, input string nm);
        int          lat, b0, wb0, ww0, t0, exp_lat;
        logic [31:0] base;
        bus_t        e;
        rsp_t        r;
        base = {v.a[31:7], 7'h0};
        if (v.we) begin
            e.we = 1'b1; e.a = v.a; e.d = v.d;
            exp_bus_q.push_back(e);
        end else if (v.miss) begin
            for (int k = 0; k < int'(WPB); k++) begin
                e.we = 1'b0; e.a = base + 32'(k * 4); e.d = '0;
                exp_bus_q.push_back(e);
            end
        end
        r.rd = !v.we; r.d = v.exp;
        exp_rsp_q.push_back(r);
        b0 = n_beats; wb0 = n_wbeats; ww0 = n_wayw; t0 = n_tagw;
        @(posedge clk);
        #1;
        cpu_bus.a  = v.a;
        cpu_bus.d  = v.d;
        cpu_bus.rd = !v.we;
        cpu_bus.we = v.we;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!cpu_bus.ready && lat < 400);
        if (!cpu_bus.ready) fail({nm, "_timeout"}, "got no cpu_ready within 400 cycles, want ready");
        @(posedge clk);
        #1;
        cpu_bus.rd = 1'b0;
        cpu_bus.we = 1'b0;
        exp_lat = v.we ? int'(2 + LAT) : (v.miss ? int'(33 + 32 * (LAT + 1)) : 1);
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_rd_beats"}, 32'(n_beats - b0), (!v.we && v.miss) ? 32'(WPB) : 32'd0);
        check({nm, "_wr_beats"}, 32'(n_wbeats - wb0), 32'(v.we));
        check({nm, "_tag_we"}, 32'(n_tagw - t0), 32'(!v.we && v.miss));
        check({nm, "_way_we"}, 32'(n_wayw - ww0),
              v.we ? 32'(!v.miss) : (v.miss ? 32'(WPB) : 32'd0));
        if (!v.we && v.miss) check({nm, "_tag_beat_addr"}, last_tag_a, base + 32'h7C);
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!way_init_done && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(nm, 32'(way_init_done), 32'd1);
    endtask

    vec_t vecs[10];
    vec_t v;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2 ms, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, n;
        vecs[0] = '{1'b0, 32'h0000_0004, 32'h0, 1'b1, pat(32'h0000_0004)};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0, 1'b0, pat(32'h0000_0008)};
        vecs[2] = '{1'b0, 32'h0000_4000, 32'h0, 1'b1, pat(32'h0000_4000)};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0, 1'b1, pat(32'h0000_0000)};
        vecs[4] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 32'h8000_0100, 32'h1234_5678, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 32'h8000_0100, 32'h0, 1'b1, 32'h1234_5678};
        vecs[8] = '{1'b0, 32'h0000_007C, 32'h0, 1'b0, pat(32'h0000_007C)};
        vecs[9] = '{1'b0, 32'h8000_017C, 32'h0, 1'b0, pat(32'h8000_017C)};

        cpu_bus.a = '0; cpu_bus.d = '0; cpu_bus.rd = 1'b0; cpu_bus.we = 1'b0;
        @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_bus.ready), 32'd0);
        check("rst_cpu_spo", cpu_bus.spo, 32'd0);
        check("rst_mem_rd", 32'(mem_bus.rd), 32'd0);
        check("rst_mem_we", 32'(mem_bus.we), 32'd0);
        check("rst_way_we", 32'({way_we, way_tag_we}), 32'd0);

        // Request held through tag init must not reach the bus or complete.
        @(negedge clk);
        rst = 1'b0;
        cpu_bus.a = 32'h4; cpu_bus.rd = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        cpu_bus.rd = 1'b0;
        check("init_no_mem_rd", 32'(n_memrd_cyc), 32'd0);
        check("init_no_ready", 32'(n_rdy), 32'd0);
        wait_init("init_done");

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            run(v, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a refill: bus read drops and the line stays invalid.
        begin
            bus_t e;
            for (int k = 0; k < int'(WPB); k++) begin
                e.we = 1'b0; e.a = 32'h2000 + 32'(k * 4); e.d = '0;
                exp_bus_q.push_back(e);
            end
        end
        b0 = n_beats;
        @(posedge clk);
        #1;
        cpu_bus.a = 32'h2004; cpu_bus.rd = 1'b1;
        n = 0;
        while (n_beats - b0 < 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_bus.rd && n < 10);
        check("midrst_beats_done", 32'(n_beats - b0), 32'd10);
        rst = 1'b1;
        cpu_bus.rd = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_mem_rd_drop", 32'(mem_bus.rd), 32'd0);
        check("midrst_beats_left", 32'(exp_bus_q.size()), 32'd22);
        exp_bus_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit_done");
        v = '{1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'hDEAD_BEEF};
        run(v, "after_reset");

        repeat (3) @(posedge clk);
        #1;
        check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
        check("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
